// File: rtl/mat_mul_pkg.sv
// Shared types and sizing helpers for the parametrised serial matrix multiplier.
package mat_mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DONE
  } mm_state_t;

  localparam logic MM_MAT = 1'b0;
  localparam logic MM_VEC = 1'b1;

  // Accumulator width that holds N full-scale DW x DW products without overflow.
  function automatic int mm_pw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate: clr loads a*b, en adds a*b; one cycle per operation.
// Result is registered; no flow control, the caller sequences clr/en.
module mac_unit #(
  parameter int DW = 16,
  parameter int PW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [PW-1:0] acc
);

  logic [2*DW-1:0] prod;
  logic [PW-1:0]   prod_ext;

  assign prod     = a * b;
  assign prod_ext = PW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= prod_ext;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/mat_mul_param.sv
// Serial NxN matrix or vector x matrix multiplier with streamed operands and addressed result readback.
// done follows the last operand by N^3+1 (matrix) or N^2+1 (vector) edges; in_ready is low only while computing.
module mat_mul_param
  import mat_mul_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int PW = mm_pw(DW, N),
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data
);

  localparam int IW = $clog2(N);
  localparam int NN = N * N;

  mm_state_t     state;
  logic          mode_q;
  logic [AW-1:0] ld_cnt;
  logic [IW-1:0] i_cnt, j_cnt, k_cnt;
  logic          drain;
  logic          wr_vld;
  logic [AW-1:0] wr_idx;

  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [PW-1:0] c_mem [NN];

  logic          xfer;
  logic          start;
  logic [AW-1:0] a_last;
  logic [IW-1:0] i_last;
  logic          mac_act;
  logic          mac_clr;
  logic          mac_en;
  logic [PW-1:0] acc;
  logic          rd_hit;

  assign xfer    = in_valid && in_ready;
  assign start   = xfer && (state == IDLE || state == DONE);
  assign a_last  = (mode_q == MM_VEC) ? AW'(N - 1) : AW'(NN - 1);
  assign i_last  = (mode_q == MM_VEC) ? '0 : '1;
  assign mac_act = (state == COMPUTE) && !drain;
  assign mac_clr = mac_act && (k_cnt == '0);
  assign mac_en  = mac_act && (k_cnt != '0);

  // In vector mode only the first row of results exists.
  assign rd_hit  = (mode_q == MM_MAT) || (rd_addr[AW-1:IW] == '0);

  mac_unit #(
    .DW (DW),
    .PW (PW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_mem[{i_cnt, k_cnt}]),
    .b     (b_mem[{k_cnt, j_cnt}]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= MM_MAT;
      ld_cnt   <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      k_cnt    <= '0;
      drain    <= 1'b0;
      wr_vld   <= 1'b0;
      wr_idx   <= '0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      wr_vld <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (xfer) begin
            mode_q <= mode;
            done   <= 1'b0;
            ld_cnt <= AW'(1);
            state  <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (xfer) begin
            if (ld_cnt == a_last) begin
              ld_cnt <= '0;
              state  <= LOAD_B;
            end else begin
              ld_cnt <= ld_cnt + AW'(1);
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            if (ld_cnt == AW'(NN - 1)) begin
              ld_cnt   <= '0;
              i_cnt    <= '0;
              j_cnt    <= '0;
              k_cnt    <= '0;
              in_ready <= 1'b0;
              state    <= COMPUTE;
            end else begin
              ld_cnt <= ld_cnt + AW'(1);
            end
          end
        end
        COMPUTE: begin
          if (!drain) begin
            // The accumulator is registered, so each result is written one cycle after its last MAC.
            wr_vld <= (k_cnt == IW'(N - 1));
            wr_idx <= {i_cnt, j_cnt};
            if (k_cnt == IW'(N - 1)) begin
              k_cnt <= '0;
              if (j_cnt == IW'(N - 1)) begin
                j_cnt <= '0;
                if (i_cnt == i_last) begin
                  drain <= 1'b1;
                end else begin
                  i_cnt <= i_cnt + IW'(1);
                end
              end else begin
                j_cnt <= j_cnt + IW'(1);
              end
            end else begin
              k_cnt <= k_cnt + IW'(1);
            end
          end else begin
            drain    <= 1'b0;
            i_cnt    <= '0;
            done     <= 1'b1;
            in_ready <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and result storage is deliberately not reset; reads are gated by done instead.
  always_ff @(posedge clk) begin
    if (start) begin
      a_mem[0] <= in_data;
    end else if (xfer && state == LOAD_A) begin
      a_mem[ld_cnt] <= in_data;
    end
    if (xfer && state == LOAD_B) begin
      b_mem[ld_cnt] <= in_data;
    end
    if (wr_vld) begin
      c_mem[wr_idx] <= acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (done && !xfer && rd_hit) begin
      rd_data <= c_mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_mat_mul_param.sv
// Directed bench for mat_mul_param (N=4): matrix, vector, overflow, backpressure, reset and back-to-back jobs.
module tb_mat_mul_param;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PW = 34;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;

  int n_chk;
  int n_pass;

  logic [DW-1:0] stim [32];

  int a_mat [16] = '{2, 8, 12, 1,  5, 15, 33, 21,  100, 0, 9, 25,  0, 2, 10, 34};
  int b_mat [16] = '{4, 16, 45, 21,  6, 3, 50, 71,  22, 0, 1, 30,  5, 15, 27, 40};
  int c_exp [16] = '{325, 71, 529, 1010,  941, 440, 1575, 3000,
                     723, 1975, 5184, 3370,  402, 516, 1028, 1802};

  mat_mul_param #(
    .N  (N),
    .DW (DW),
    .PW (PW),
    .AW (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic load_mat_stim();
    for (int w = 0; w < 16; w++) begin
      stim[w]      = DW'(a_mat[w]);
      stim[16 + w] = DW'(b_mat[w]);
    end
  endtask

  // Vector x, then W = scale * identity.
  task automatic load_vec_stim(input int x0, input int scale);
    for (int w = 0; w < 4; w++) stim[w] = DW'(x0 + w);
    for (int w = 0; w < 16; w++) stim[4 + w] = (w % 5 == 0) ? DW'(scale) : '0;
  endtask

  task automatic send_job(input logic m, input int nw, input bit rnd, input bit b2b);
    for (int w = 0; w < nw; w++) begin
      if (rnd) begin
        int gap;
        gap = $urandom_range(0, 3);
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      mode     = m;
      in_data  = stim[w];
      in_valid = 1'b1;
      if (!in_ready) chk($sformatf("ready_in_load[%0d]", w), in_ready, 1);
      @(posedge clk);
      #1;
      if (b2b && w == 0) begin
        chk("b2b_done_falls", done, 0);
        chk("b2b_rd_zero", rd_data, 0);
      end
    end
    in_data = 16'hBEEF;
  endtask

  // Called right after the edge accepting the final word; in_valid stays high through compute.
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc;
    int lowc;
    cyc  = 0;
    lowc = 0;
    if (!in_ready) lowc++;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!in_ready) lowc++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_ready_low_cycles"}, lowc, exp_lat);
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [63:0] exp);
    rd_addr = AW'(addr);
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d]", tag, addr), rd_data, exp);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_addr  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Matrix product, in_valid held high.
    load_mat_stim();
    send_job(1'b0, 32, 1'b0, 1'b0);
    wait_done("mat", 65);
    for (int a = 0; a < 16; a++) read_chk("mat", a, c_exp[a]);

    // Full-scale operands, started while done has been high for a while and C[0] is being read.
    rd_addr = '0;
    @(posedge clk);
    #1;
    chk("pre_b2b_read", rd_data, 325);
    for (int w = 0; w < 32; w++) stim[w] = 16'hFFFF;
    send_job(1'b0, 32, 1'b0, 1'b1);
    wait_done("ovf", 65);

    // Vector job started in the very first done cycle.
    load_vec_stim(1, 1);
    send_job(1'b1, 20, 1'b0, 1'b1);
    wait_done("vec", 17);
    for (int a = 0; a < 16; a++) read_chk("vec", a, (a < 4) ? 64'(a + 1) : 64'd0);

    // Overflow results were overwritten only in mode-1 positions? No: re-run to read them cleanly.
    for (int w = 0; w < 32; w++) stim[w] = 16'hFFFF;
    send_job(1'b0, 32, 1'b0, 1'b0);
    wait_done("ovf2", 65);
    for (int a = 0; a < 16; a += 5) read_chk("ovf", a, 64'h3_FFF8_0004);
    read_chk("ovf", 15, 64'h3_FFF8_0004);

    // Random in_valid gaps during both loads.
    load_mat_stim();
    send_job(1'b0, 32, 1'b1, 1'b0);
    wait_done("bp", 65);
    for (int a = 0; a < 16; a++) read_chk("bp", a, c_exp[a]);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_extra_words", done, 1);

    // Reset in the middle of compute, then a fresh vector job.
    load_mat_stim();
    send_job(1'b0, 32, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_compute_busy", in_ready, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_vec_stim(5, 2);
    send_job(1'b1, 20, 1'b0, 1'b0);
    wait_done("vec_after_rst", 17);
    for (int a = 0; a < 4; a++) read_chk("vec2", a, 64'(2 * (a + 5)));
    read_chk("vec2", 4, 0);
    read_chk("vec2", 12, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
